// File: rtl/vga_update_arbiter.sv
// vga_update_arbiter: round-robin merge of two display writers into a shadow committed once per frame at vblank start
module vga_update_arbiter #(
  parameter int VBLANK_LINE = 480,
  parameter int CNT_W = 10
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] horiz_count,
  input  logic [CNT_W-1:0] vert_count,
  input  logic             a_req,
  input  logic [1:0]       a_mask,
  input  logic [7:0]       a_dest,
  input  logic [25:0]      a_people,
  input  logic [1:0]       a_state,
  input  logic             b_req,
  input  logic [1:0]       b_mask,
  input  logic [7:0]       b_dest,
  input  logic [25:0]      b_people,
  input  logic [1:0]       b_state,
  output logic             a_ack,
  output logic             b_ack,
  output logic [7:0]       destination,
  output logic [25:0]      people_data,
  output logic [1:0]       sim_state,
  output logic             update_pending,
  output logic [7:0]       frame_count
);
  logic w_hit, w_commit, w_a_elig, w_b_elig, w_grant_a, w_grant_b;
  logic [1:0] w_mask, w_state;
  logic [7:0] w_dest;
  logic [25:0] w_people;
  logic r_rr, r_commit_prev, r_dirty;
  logic [7:0] r_s_dest;
  logic [25:0] r_s_people;
  logic [1:0] r_s_state;
  always_comb begin
    w_hit = (horiz_count == '0) && (vert_count == CNT_W'(VBLANK_LINE));
    w_commit = w_hit && !r_commit_prev;
    w_a_elig = a_req && !a_ack;
    w_b_elig = b_req && !b_ack;
    w_grant_a = !w_commit && w_a_elig && (!w_b_elig || !r_rr);
    w_grant_b = !w_commit && w_b_elig && (!w_a_elig || r_rr);
    w_mask = w_grant_a ? a_mask : w_grant_b ? b_mask : 2'b00;
    w_dest = w_grant_a ? a_dest : b_dest;
    w_people = w_grant_a ? a_people : b_people;
    w_state = w_grant_a ? a_state : b_state;
  end
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      destination <= '0;
      people_data <= '0;
      sim_state <= '0;
      frame_count <= '0;
      r_rr <= 1'b0;
      r_commit_prev <= 1'b0;
      r_dirty <= 1'b0;
      r_s_dest <= '0;
      r_s_people <= '0;
      r_s_state <= '0;
    end else begin
      a_ack <= w_grant_a;
      b_ack <= w_grant_b;
      r_commit_prev <= w_hit;
      if (w_grant_a || w_grant_b) r_rr <= w_grant_a;
      if (w_mask[0]) begin
        r_s_dest <= w_dest;
        r_s_people <= w_people;
      end
      if (w_mask[1]) r_s_state <= w_state;
      if (w_commit) begin
        frame_count <= frame_count + 8'd1;
        r_dirty <= 1'b0;
        if (r_dirty) begin
          destination <= r_s_dest;
          people_data <= r_s_people;
          sim_state <= r_s_state;
        end
      end else if (|w_mask) r_dirty <= 1'b1;
    end
  end
  assign update_pending = r_dirty;
endmodule

// File: tb/tb_vga_update_arbiter.sv
// tb_vga_update_arbiter: directed checks of arbitration, handshake, frame commit and reset
module tb_vga_update_arbiter;
  logic pixel_clk = 0, reset = 1;
  logic [9:0] horiz_count = 10'd5, vert_count = 10'd0;
  logic a_req = 0, b_req = 0;
  logic [1:0] a_mask = 0, b_mask = 0, a_state = 0, b_state = 0;
  logic [7:0] a_dest = 0, b_dest = 0;
  logic [25:0] a_people = 0, b_people = 0;
  logic a_ack, b_ack, update_pending;
  logic [7:0] destination, frame_count;
  logic [25:0] people_data;
  logic [1:0] sim_state;
  int n_chk = 0, n_pass = 0;
  vga_update_arbiter dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .horiz_count(horiz_count), .vert_count(vert_count),
    .a_req(a_req), .a_mask(a_mask), .a_dest(a_dest), .a_people(a_people), .a_state(a_state),
    .b_req(b_req), .b_mask(b_mask), .b_dest(b_dest), .b_people(b_people), .b_state(b_state),
    .a_ack(a_ack), .b_ack(b_ack),
    .destination(destination), .people_data(people_data), .sim_state(sim_state),
    .update_pending(update_pending), .frame_count(frame_count)
  );
  always #5 pixel_clk = ~pixel_clk;
  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  // one frame: sit on the commit point for a cycle, then leave it
  task automatic frame();
    horiz_count = 10'd0;
    vert_count = 10'd480;
    tick();
    horiz_count = 10'd5;
    vert_count = 10'd0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_dest", destination, 0);
    chk("rst_people", people_data, 0);
    chk("rst_state", sim_state, 0);
    chk("rst_pending", update_pending, 0);
    chk("rst_fc", frame_count, 0);
    reset = 0;
    tick();
    a_req = 1; a_mask = 2'b01; a_dest = 8'h05; a_people = 26'h1234;
    tick();
    chk("a1_ack", a_ack, 1);
    chk("a1_b_ack", b_ack, 0);
    chk("a1_pending", update_pending, 1);
    chk("a1_dest_held", destination, 0);
    a_req = 0;
    tick();
    chk("a1_ack_pulse", a_ack, 0);
    chk("a1_dest_still", destination, 0);
    horiz_count = 10'd0; vert_count = 10'd480;
    tick();
    chk("c1_dest", destination, 8'h05);
    chk("c1_people", people_data, 26'h1234);
    chk("c1_fc", frame_count, 1);
    chk("c1_pending", update_pending, 0);
    repeat (4) tick();
    chk("stall_fc", frame_count, 1);
    horiz_count = 10'd5; vert_count = 10'd0;
    tick();
    a_req = 1; a_mask = 2'b10; a_state = 2'd1;
    b_req = 1; b_mask = 2'b10; b_state = 2'd2;
    tick();
    chk("rr1_b_first", b_ack, 1);
    chk("rr1_a_wait", a_ack, 0);
    b_req = 0;
    tick();
    chk("rr1_a_next", a_ack, 1);
    chk("rr1_b_done", b_ack, 0);
    a_req = 0;
    tick();
    chk("st_uncommitted", sim_state, 0);
    chk("st_pending", update_pending, 1);
    frame();
    chk("st_commit", sim_state, 1);
    chk("st_dest_kept", destination, 8'h05);
    chk("st_fc", frame_count, 2);
    a_req = 1; a_mask = 0; b_req = 1; b_mask = 0;
    tick();
    chk("rr2_b_first", b_ack, 1);
    b_req = 0;
    tick();
    chk("rr2_a_next", a_ack, 1);
    a_req = 0;
    tick();
    chk("mask0_clean", update_pending, 0);
    b_req = 1;
    tick();
    chk("b_alone", b_ack, 1);
    b_req = 0;
    tick();
    a_req = 1; b_req = 1;
    tick();
    chk("rr3_a_first", a_ack, 1);
    chk("rr3_b_wait", b_ack, 0);
    a_req = 0;
    tick();
    chk("rr3_b_next", b_ack, 1);
    b_req = 0;
    tick();
    a_req = 1; a_mask = 2'b01; a_dest = 8'h77; a_people = 26'h55;
    horiz_count = 10'd0; vert_count = 10'd480;
    tick();
    chk("col_no_ack", a_ack, 0);
    chk("col_fc", frame_count, 3);
    chk("col_dest", destination, 8'h05);
    horiz_count = 10'd5; vert_count = 10'd0;
    tick();
    chk("col_late_ack", a_ack, 1);
    chk("col_pending", update_pending, 1);
    a_req = 0;
    tick();
    chk("col_dest_wait", destination, 8'h05);
    frame();
    chk("col_dest_next", destination, 8'h77);
    chk("col_people_next", people_data, 26'h55);
    chk("col_fc_next", frame_count, 4);
    repeat (251) frame();
    chk("fc_255", frame_count, 255);
    frame();
    chk("fc_wrap", frame_count, 0);
    a_req = 1; a_mask = 2'b11; a_dest = 8'hAA; a_people = 26'h1; a_state = 2'd3;
    tick();
    chk("pre_rst_ack", a_ack, 1);
    chk("pre_rst_pending", update_pending, 1);
    a_req = 0; b_req = 1; b_mask = 2'b01;
    #2 reset = 1;
    #1;
    chk("mid_rst_pending", update_pending, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_a_ack", a_ack, 0);
    chk("mid_rst_state", sim_state, 0);
    chk("mid_rst_dest", destination, 0);
    b_req = 0;
    tick();
    reset = 0;
    tick();
    chk("post_rst_b_ack", b_ack, 0);
    frame();
    chk("post_rst_dest", destination, 0);
    chk("post_rst_people", people_data, 0);
    chk("post_rst_state", sim_state, 0);
    chk("post_rst_fc", frame_count, 1);
    chk("post_rst_pending", update_pending, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
